pc_sequencer: RTL and testbench

Program-counter sequencer for the ECAP5-DPROC front end. It produces the fetch address stream under a valid/ready handshake and resolves conditional branches using the core's branch-condition encoding. It also accepts interrupt and debug requests, redirecting to their vectors, and squashes fetch for a configurable flush window after every redirect. It sits between the execute stage (branch outcome) and the instruction fetch unit, and replaces the fixed-constant vector scheme with parametrised vectors and widths.

---
 rtl/pc_sequencer_if.sv | 50 +++++
 rtl/pc_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side handshake, branch-resolution and redirect-request signals of the
// PC sequencer, bundled so the front end can be wired with a single port.
interface pc_sequencer_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc_o;
   logic            pc_valid_o;
   logic            pc_ready_i;
   logic            branch_valid_i;
   logic [2:0]      branch_cond_i;
   logic [XLEN-1:0] branch_op1_i;
   logic [XLEN-1:0] branch_op2_i;
   logic [XLEN-1:0] branch_target_i;
   logic            irq_i;
   logic            dbg_i;
   logic            flush_o;
   logic            taken_o;

   // Sequencer side: drives the fetch address and redirect pulses.
   modport master (
      output pc_o,
      output pc_valid_o,
      input  pc_ready_i,
      input  branch_valid_i,
      input  branch_cond_i,
      input  branch_op1_i,
      input  branch_op2_i,
      input  branch_target_i,
      input  irq_i,
      input  dbg_i,
      output flush_o,
      output taken_o
   );

   // Environment side: fetch unit, execute stage and request sources.
   modport slave (
      input  pc_o,
      input  pc_valid_o,
      output pc_ready_i,
      output branch_valid_i,
      output branch_cond_i,
      output branch_op1_i,
      output branch_op2_i,
      output branch_target_i,
      output irq_i,
      output dbg_i,
      input  flush_o,
      input  taken_o
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch addresses under valid/ready,
// branch/interrupt/debug redirects followed by a fixed-length fetch squash.
module pc_sequencer #(
   parameter int              XLEN              = 32,
   parameter logic [XLEN-1:0] BOOT_ADDRESS      = 32'h00000000,
   parameter logic [XLEN-1:0] INTERRUPT_ADDRESS = 32'hFF00000A,
   parameter logic [XLEN-1:0] DEBUG_ADDRESS     = 32'hFF00000B,
   parameter int              INSTR_BYTES       = 4,
   parameter int              FLUSH_CYCLES      = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   pc_sequencer_if.master   bus,
   output logic [1:0]       dbg_state_o
);

   // Handshake: pc_o is offered while pc_valid_o=1; it is consumed on a rising
   // edge where pc_valid_o && pc_ready_i, otherwise it is held unchanged. A
   // redirect drops pc_valid_o and abandons any offered address without accept.

   localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLT  = 3'd3,
      BR_BLTU = 3'd4,
      BR_BGE  = 3'd5,
      BR_BGEU = 3'd6,
      BR_RSVD = 3'd7
   } branch_cond_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            dbg_pend_q, dbg_pend_d;
   logic            irq_pend_q, irq_pend_d;
   logic            flush_q, flush_d;
   logic            taken_q, taken_d;

   logic            cond_true;
   logic            dbg_req;
   logic            irq_req;
   logic            branch_req;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   // Branch condition evaluation, independent of state.
   always_comb begin
      cond_true = 1'b0;
      case (branch_cond_t'(bus.branch_cond_i))
         BR_BEQ:  cond_true = (bus.branch_op1_i == bus.branch_op2_i);
         BR_BNE:  cond_true = (bus.branch_op1_i != bus.branch_op2_i);
         BR_BLT:  cond_true = ($signed(bus.branch_op1_i) <  $signed(bus.branch_op2_i));
         BR_BLTU: cond_true = (bus.branch_op1_i <  bus.branch_op2_i);
         BR_BGE:  cond_true = ($signed(bus.branch_op1_i) >= $signed(bus.branch_op2_i));
         BR_BGEU: cond_true = (bus.branch_op1_i >= bus.branch_op2_i);
         default: cond_true = 1'b0;
      endcase
   end

   // Redirect arbitration: debug beats interrupt beats a taken branch. A pulse
   // arriving this cycle counts the same as an already-pending request.
   always_comb begin
      dbg_req     = 1'b0;
      irq_req     = 1'b0;
      branch_req  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = pc_q;
      if (state_q != ST_RESET) begin
         if (dbg_pend_q || bus.dbg_i) begin
            dbg_req     = 1'b1;
            redirect    = 1'b1;
            redirect_pc = DEBUG_ADDRESS;
         end else if (irq_pend_q || bus.irq_i) begin
            irq_req     = 1'b1;
            redirect    = 1'b1;
            redirect_pc = INTERRUPT_ADDRESS;
         end else if (state_q == ST_RUN && bus.branch_valid_i && cond_true) begin
            branch_req  = 1'b1;
            redirect    = 1'b1;
            redirect_pc = bus.branch_target_i;
         end
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      dbg_pend_d = dbg_pend_q;
      irq_pend_d = irq_pend_q;
      flush_d    = 1'b0;
      taken_d    = 1'b0;

      case (state_q)
         ST_RESET: begin
            state_d    = ST_RUN;
            pc_d       = BOOT_ADDRESS;
            cnt_d      = '0;
            dbg_pend_d = 1'b0;
            irq_pend_d = 1'b0;
         end
         ST_RUN, ST_FLUSH: begin
            // Requests stay sticky until their own redirect is taken.
            dbg_pend_d = (dbg_pend_q || bus.dbg_i) && !dbg_req;
            irq_pend_d = (irq_pend_q || bus.irq_i) && !irq_req;
            if (redirect) begin
               state_d = ST_FLUSH;
               pc_d    = redirect_pc;
               cnt_d   = CNT_W'(FLUSH_CYCLES);
               flush_d = 1'b1;
               taken_d = branch_req;
            end else if (state_q == ST_RUN) begin
               if (bus.pc_ready_i) begin
                  pc_d = pc_q + XLEN'(INSTR_BYTES);
               end
            end else if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= ST_RESET;
         pc_q       <= BOOT_ADDRESS;
         cnt_q      <= '0;
         dbg_pend_q <= 1'b0;
         irq_pend_q <= 1'b0;
         flush_q    <= 1'b0;
         taken_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         dbg_pend_q <= dbg_pend_d;
         irq_pend_q <= irq_pend_d;
         flush_q    <= flush_d;
         taken_q    <= taken_d;
      end
   end

   assign bus.pc_o       = pc_q;
   assign bus.pc_valid_o = (state_q == ST_RUN);
   assign bus.flush_o    = flush_q;
   assign bus.taken_o    = taken_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, stalls, branch conditions,
// redirect priority, address wrap and reset during a flush.
module tb_pc_sequencer;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic [1:0] dbg_state_o;

   int checks   = 0;
   int failures = 0;

   pc_sequencer_if #(.XLEN(32)) bus ();

   pc_sequencer dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .bus         (bus.master),
      .dbg_state_o (dbg_state_o)
   );

   // Clock and reset
   always #5 clk_i = ~clk_i;

   // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.branch_valid_i  = 1'b0;
      bus.branch_cond_i   = 3'd0;
      bus.branch_op1_i    = '0;
      bus.branch_op2_i    = '0;
      bus.branch_target_i = '0;
      bus.irq_i           = 1'b0;
      bus.dbg_i           = 1'b0;
   endtask

   task automatic drive_branch(input logic [2:0] cond, input logic [31:0] op1,
                               input logic [31:0] op2, input logic [31:0] target);
      bus.branch_valid_i  = 1'b1;
      bus.branch_cond_i   = cond;
      bus.branch_op1_i    = op1;
      bus.branch_op2_i    = op2;
      bus.branch_target_i = target;
   endtask

   task automatic check_out(input string tag, input logic [31:0] pc, input logic valid,
                            input logic flush, input logic taken);
      check_eq({tag, ".pc"},    bus.pc_o,       pc);
      check_eq({tag, ".valid"}, 32'(bus.pc_valid_o), 32'(valid));
      check_eq({tag, ".flush"}, 32'(bus.flush_o),    32'(flush));
      check_eq({tag, ".taken"}, 32'(bus.taken_o),    32'(taken));
   endtask

   initial begin
      bus.pc_ready_i = 1'b0;
      idle_inputs();

      // Reset state
      tick();
      tick();
      check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      check_eq("reset.state", 32'(dbg_state_o), 32'd0);

      // Release: valid rises one edge later at BOOT_ADDRESS
      rst_i = 1'b1;
      bus.pc_ready_i = 1'b1;
      tick(); check_out("seq0", 32'h0, 1'b1, 1'b0, 1'b0);
      tick(); check_out("seq1", 32'h4, 1'b1, 1'b0, 1'b0);
      tick(); check_out("seq2", 32'h8, 1'b1, 1'b0, 1'b0);

      // Stall holds pc_o and valid
      bus.pc_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); check_out("stall", 32'h8, 1'b1, 1'b0, 1'b0);
      end
      bus.pc_ready_i = 1'b1;
      tick(); check_out("resume", 32'hC, 1'b1, 1'b0, 1'b0);
      tick(); check_out("seq4", 32'h10, 1'b1, 1'b0, 1'b0);

      // Signed BLT taken: -1 < 1
      drive_branch(3'd3, 32'hFFFF_FFFF, 32'h1, 32'h100);
      tick(); check_out("blt.redir", 32'h100, 1'b0, 1'b1, 1'b1);
      check_eq("blt.state", 32'(dbg_state_o), 32'd2);
      idle_inputs();
      tick(); check_out("blt.flush1", 32'h100, 1'b0, 1'b0, 1'b0);
      tick(); check_out("blt.valid", 32'h100, 1'b1, 1'b0, 1'b0);
      tick(); check_out("blt.next", 32'h104, 1'b1, 1'b0, 1'b0);

      // Not-taken cases: BLTU 0xFFFFFFFF<1, BNE equal, BGE -1>=1, reserved code
      drive_branch(3'd4, 32'hFFFF_FFFF, 32'h1, 32'h200);
      tick(); check_out("bltu.nt", 32'h108, 1'b1, 1'b0, 1'b0);
      drive_branch(3'd2, 32'h55, 32'h55, 32'h200);
      tick(); check_out("bne.nt", 32'h10C, 1'b1, 1'b0, 1'b0);
      drive_branch(3'd5, 32'hFFFF_FFFF, 32'h1, 32'h200);
      tick(); check_out("bge.nt", 32'h110, 1'b1, 1'b0, 1'b0);
      drive_branch(3'd7, 32'h1, 32'h1, 32'h200);
      tick(); check_out("rsvd.nt", 32'h114, 1'b1, 1'b0, 1'b0);

      // Debug + interrupt + taken BGEU in one cycle: debug first, then irq
      drive_branch(3'd6, 32'h9, 32'h3, 32'h300);
      bus.irq_i = 1'b1;
      bus.dbg_i = 1'b1;
      tick(); check_out("prio.dbg", 32'hFF00_000B, 1'b0, 1'b1, 1'b0);
      idle_inputs();
      tick(); check_out("prio.irq", 32'hFF00_000A, 1'b0, 1'b1, 1'b0);
      tick(); check_out("prio.flush", 32'hFF00_000A, 1'b0, 1'b0, 1'b0);
      tick(); check_out("prio.valid", 32'hFF00_000A, 1'b1, 1'b0, 1'b0);
      tick(); check_out("prio.next", 32'hFF00_000E, 1'b1, 1'b0, 1'b0);

      // Interrupt preempts a stalled handshake
      bus.pc_ready_i = 1'b0;
      tick(); check_out("pre.stall", 32'hFF00_000E, 1'b1, 1'b0, 1'b0);
      bus.irq_i = 1'b1;
      tick(); check_out("pre.irq", 32'hFF00_000A, 1'b0, 1'b1, 1'b0);
      bus.irq_i = 1'b0;
      bus.pc_ready_i = 1'b1;
      tick(); tick(); check_out("pre.valid", 32'hFF00_000A, 1'b1, 1'b0, 1'b0);

      // Wrap: BEQ to 0xFFFFFFFC, then one accept wraps to 0
      drive_branch(3'd1, 32'h5, 32'h5, 32'hFFFF_FFFC);
      tick(); check_out("wrap.redir", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
      idle_inputs();
      tick(); tick(); check_out("wrap.valid", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
      tick(); check_out("wrap.zero", 32'h0, 1'b1, 1'b0, 1'b0);

      // Reset during FLUSH with an interrupt still pending
      bus.dbg_i = 1'b1;
      bus.irq_i = 1'b1;
      tick(); check_out("rst.dbg", 32'hFF00_000B, 1'b0, 1'b1, 1'b0);
      idle_inputs();
      rst_i = 1'b0;
      tick(); check_out("rst.hold", 32'h0, 1'b0, 1'b0, 1'b0);
      check_eq("rst.state", 32'(dbg_state_o), 32'd0);
      rst_i = 1'b1;
      tick(); check_out("rst.run", 32'h0, 1'b1, 1'b0, 1'b0);
      tick(); check_out("rst.seq1", 32'h4, 1'b1, 1'b0, 1'b0);
      tick(); check_out("rst.seq2", 32'h8, 1'b1, 1'b0, 1'b0);
      tick(); check_out("rst.seq3", 32'hC, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
